snn_input_buffer: RTL

SNN_INPUT_BUFFER -- requirements
Module: snn_input_buffer

---
 rtl/snn_input_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/snn_input_buffer.sv
// rtl/snn_input_buffer.sv - first-word-fall-through packet FIFO feeding the SNN grid (optional stats: SNN_INBUF_STATS_EN)
module snn_input_buffer #(
    parameter int DEPTH = 16,
    parameter int PKT_W = 30
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wen,
    input  logic [PKT_W-1:0]           wdata,
    input  logic                       flush,
    input  logic                       clear_err,
    input  logic                       ren,
    output logic [PKT_W-1:0]           packet_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow,
    output logic [15:0]                accepted_cnt,
    output logic [15:0]                dropped_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [PKT_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic do_pop;
    logic do_push;
    logic ov_set;
    logic uf_set;

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign level = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Head of queue shown straight from storage; zero when nothing is queued.
    assign packet_out = empty ? '0 : mem_q[rd_ptr_q];

    // Decide which of push/pop actually happen this cycle and the resulting state.
    always_comb begin
        do_pop  = ren && !empty && !flush;
        // A full queue still accepts a write when the grid pops in the same cycle.
        do_push = wen && (!full || ren) && !flush;
        ov_set  = wen && full && !ren && !flush;
        uf_set  = ren && empty && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end

        // A new error event in the same cycle as clear_err keeps the flag set.
        overflow_d  = clear_err ? ov_set : (overflow_q  || ov_set);
        underflow_d = clear_err ? uf_set : (underflow_q || uf_set);
    end

    // Pointer, occupancy and sticky flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Packet storage; deliberately not reset, and writes during reset are lost.
    always_ff @(posedge clk) begin
        if (reset_n && do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

`ifdef SNN_INBUF_STATS_EN
    logic [15:0] acc_cnt_q, acc_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating accepted/dropped packet counters, cleared together with the flags.
    always_comb begin
        acc_cnt_d  = acc_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_err) begin
            acc_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (do_push && acc_cnt_q != 16'hFFFF) begin
                acc_cnt_d = acc_cnt_q + 16'd1;
            end
            if (ov_set && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign accepted_cnt = acc_cnt_q;
    assign dropped_cnt  = drop_cnt_q;
`else
    assign accepted_cnt = 16'h0000;
    assign dropped_cnt  = 16'h0000;
`endif

endmodule
